// File: rtl/alu_share_arb.sv
// alu_share_arb
// -----------------------------------------------------------------------------
// Two-requester arbiter and sequencer for a shared, purely combinational 8-bit
// ALU. An operation is accepted from one requester at a time and its operands
// are registered into the ALU. The ALU gets one full clock to settle. Its result
// and overflow flag are then captured and held for the requester that issued
// the operation until that requester takes them.
//
// Optional feature macro: ALU_ARB_FAIR_EN
//   defined   : round-robin arbitration. The pointer flips after every
//               completed response handshake.
//   undefined : fixed priority (req0 wins whenever it is valid). No pointer
//               register is built.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid / reqN_ready   operation handshake for requester N (ready is
//                             combinational and only asserted in IDLE)
//   reqN_a, reqN_b, reqN_op   operation payload for requester N
//   alu_a, alu_b, alu_op      registered operands/opcode into the ALU
//   alu_y, alu_ovf            combinational ALU result/flag
//   rspN_valid / rspN_ready   result handshake for requester N
//   rsp_y, rsp_ovf            captured result/flag shared by both response ports
// -----------------------------------------------------------------------------
module alu_share_arb #(
    parameter int W   = 8,
    parameter int OPW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_y,
    input  logic           alu_ovf,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [W-1:0]   rsp_y,
    output logic           rsp_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state_r;
    state_t state_s;
    logic   owner_r;    // 1'b0: req0 owns the in-flight operation, 1'b1: req1
    logic   pick1_s;    // arbitration winner if a grant happens this cycle
    logic   accept_s;   // an operation is accepted on the coming edge
    logic   done_s;     // response handshake completes on the coming edge

`ifdef ALU_ARB_FAIR_EN
    logic   ptr_r;      // requester preferred when both are valid

    // Round-robin winner selection: the pointer only matters under contention.
    always_comb begin
        pick1_s = 1'b0;
        if (req0_valid && req1_valid) begin
            pick1_s = ptr_r;
        end else if (req1_valid) begin
            pick1_s = 1'b1;
        end else begin
            pick1_s = 1'b0;
        end
    end
`else
    // Fixed-priority winner selection: req1 only when req0 is idle.
    always_comb begin
        pick1_s = 1'b0;
        if (req0_valid) begin
            pick1_s = 1'b0;
        end else if (req1_valid) begin
            pick1_s = 1'b1;
        end else begin
            pick1_s = 1'b0;
        end
    end
`endif

    // Grant and handshake qualifiers; ready is forced low while in reset.
    always_comb begin
        accept_s   = (state_r == IDLE) && !rst && (req0_valid || req1_valid);
        req0_ready = accept_s && !pick1_s;
        req1_ready = accept_s && pick1_s;
        done_s     = (state_r == RESP) && (owner_r ? rsp1_ready : rsp0_ready);
    end

    // Next-state logic for the IDLE -> ISSUE -> RESP sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s = RESP;
            end
            RESP: begin
                if (done_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand registers: loaded only on acceptance so the ALU inputs stay quiet otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a   <= {W{1'b0}};
            alu_b   <= {W{1'b0}};
            alu_op  <= {OPW{1'b0}};
            owner_r <= 1'b0;
        end else if (accept_s) begin
            alu_a   <= pick1_s ? req1_a  : req0_a;
            alu_b   <= pick1_s ? req1_b  : req0_b;
            alu_op  <= pick1_s ? req1_op : req0_op;
            owner_r <= pick1_s;
        end
    end

    // Result capture at the end of the ALU settle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_y   <= {W{1'b0}};
            rsp_ovf <= 1'b0;
        end else if (state_r == ISSUE) begin
            rsp_y   <= alu_y;
            rsp_ovf <= alu_ovf;
        end
    end

    // Response valid flags, set with the capture and cleared on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else if (state_r == ISSUE) begin
            rsp0_valid <= !owner_r;
            rsp1_valid <= owner_r;
        end else if (done_s) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end
    end

`ifdef ALU_ARB_FAIR_EN
    // Round-robin pointer flips after every completed response, whoever was served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 1'b0;
        end else if (done_s) begin
            ptr_r <= ~ptr_r;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: a stub combinational ALU, a
// transaction-level reference model, a per-cycle compare process, directed
// scenarios with literal expectations, then randomized traffic.
module tb_alu_share_arb;
    localparam int W   = 8;
    localparam int OPW = 2;
`ifdef ALU_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0] req0_op, req1_op;
    logic [W-1:0]   alu_a, alu_b, alu_y, rsp_y;
    logic [OPW-1:0] alu_op;
    logic           alu_ovf, rsp_ovf;
    logic           rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_share_arb #(.W(W), .OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_ovf(alu_ovf),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_y(rsp_y), .rsp_ovf(rsp_ovf)
    );

    // Stub ALU: 0 add, 1 sub, 2 and, 3 xor; ovf is signed overflow for add/sub.
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        logic [7:0] y;
        logic       v;
        case (op)
            2'd0: begin y = a + b; v = (a[7] == b[7]) && (y[7] != a[7]); end
            2'd1: begin y = a - b; v = (a[7] != b[7]) && (y[7] != a[7]); end
            2'd2: begin y = a & b; v = 1'b0; end
            default: begin y = a ^ b; v = 1'b0; end
        endcase
        return {v, y};
    endfunction

    assign {alu_ovf, alu_y} = alu_fn(alu_a, alu_b, alu_op);

    // ---------------- reference model (transaction level) ----------------
    bit         m_busy;
    bit         m_owner;
    int         m_age;     // cycles since acceptance; result held once >= 2
    bit         m_pref;
    logic [7:0] m_a, m_b, m_y;
    logic [1:0] m_op;
    bit         m_ovf;
    bit         acc0, acc1;

    function automatic int m_pick();
        if (rst || m_busy) return -1;
        if (req0_valid && req1_valid) return FAIR ? int'(m_pref) : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        g = m_pick();
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_pref = 1'b0; m_age = 0; m_owner = 1'b0;
            m_a = 8'h00; m_b = 8'h00; m_op = 2'd0; m_y = 8'h00; m_ovf = 1'b0;
        end else if (!m_busy) begin
            if (g >= 0) begin
                m_a     = (g == 1) ? req1_a  : req0_a;
                m_b     = (g == 1) ? req1_b  : req0_b;
                m_op    = (g == 1) ? req1_op : req0_op;
                m_owner = (g == 1);
                m_busy  = 1'b1;
                m_age   = 1;
                acc0    = (g == 0);
                acc1    = (g == 1);
            end
        end else if (m_age == 1) begin
            {m_ovf, m_y} = alu_fn(m_a, m_b, m_op);
            m_age = 2;
        end else if ((!m_owner && rsp0_ready) || (m_owner && rsp1_ready)) begin
            m_busy = 1'b0;
            if (FAIR) m_pref = ~m_pref;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        int g;
        if (chk_en) begin
            g = m_pick();
            check("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
            check("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
            check("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_busy && m_age == 2 && !m_owner});
            check("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_busy && m_age == 2 && m_owner});
            check("alu_a", {24'd0, alu_a}, {24'd0, m_a});
            check("alu_b", {24'd0, alu_b}, {24'd0, m_b});
            check("alu_op", {30'd0, alu_op}, {30'd0, m_op});
            check("rsp_y", {24'd0, rsp_y}, {24'd0, m_y});
            check("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, m_ovf});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    int gq[$];

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h00; req0_b = 8'h00; req0_op = 2'd0;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_op = 2'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        step();
        chk_en = 1'b1;
        at_neg();
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_alu_a", {24'd0, alu_a}, 32'd0);

        // Single op: 7F + 01 -> 80, overflow.
        step();
        rst = 1'b0; req0_valid = 1'b1; req0_a = 8'h7F; req0_b = 8'h01; req0_op = 2'd0;
        at_neg();
        check("single_ready", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        at_neg();
        check("single_issue_valid", {31'd0, rsp0_valid}, 32'd0);
        check("single_alu_a", {24'd0, alu_a}, 32'h7F);
        step();
        at_neg();
        check("single_rsp_valid", {31'd0, rsp0_valid}, 32'd1);
        check("single_rsp_y", {24'd0, rsp_y}, 32'h80);
        check("single_rsp_ovf", {31'd0, rsp_ovf}, 32'd1);
        step();
        rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;
        at_neg();
        check("single_done", {31'd0, rsp0_valid}, 32'd0);

        // Contention with responses always taken.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_op = 2'd0;
        req1_valid = 1'b1; req1_a = 8'h03; req1_b = 8'h04; req1_op = 2'd1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            at_neg();
            if (req0_ready) gq.push_back(0);
            if (req1_ready) gq.push_back(1);
            step();
        end
        check("cont_grants", gq.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < gq.size()) check("cont_order", gq[i], FAIR ? (i % 2) : 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step(); step(); step();

        // Backpressure on requester 1.
        rsp1_ready = 1'b0; rsp0_ready = 1'b1;
        req1_valid = 1'b1; req1_a = 8'hF0; req1_b = 8'h20; req1_op = 2'd0;
        at_neg();
        for (int i = 0; i < 10 && !req1_ready; i++) begin step(); at_neg(); end
        check("bp_grant", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h06; req0_op = 2'd2;
        at_neg();
        for (int i = 0; i < 10 && !rsp1_valid; i++) begin step(); at_neg(); end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, rsp1_valid}, 32'd1);
            check("bp_y", {24'd0, rsp_y}, 32'h10);
            check("bp_ovf", {31'd0, rsp_ovf}, 32'd0);
            check("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
            step();
            at_neg();
        end
        step();
        rsp1_ready = 1'b1;
        at_neg();
        check("bp_still_resp", {31'd0, req0_ready}, 32'd0);
        step();
        at_neg();
        check("bp_idle_again", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0; rsp1_ready = 1'b0;
        step(); step(); step();

        // Hold check: req1 arrives while req0's op is in flight.
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h44; req0_b = 8'h11; req0_op = 2'd1;
        at_neg();
        for (int i = 0; i < 10 && !req0_ready; i++) begin step(); at_neg(); end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h00; req1_op = 2'd1;
        at_neg();
        check("hold_issue_a", {24'd0, alu_a}, 32'h44);
        check("hold_issue_r1", {31'd0, req1_ready}, 32'd0);
        step();
        at_neg();
        check("hold_resp_a", {24'd0, alu_a}, 32'h44);
        check("hold_resp_y", {24'd0, rsp_y}, 32'h33);
        check("hold_resp_r1", {31'd0, req1_ready}, 32'd0);
        step();
        rsp0_ready = 1'b1;
        at_neg();
        check("hold_resp2_a", {24'd0, alu_a}, 32'h44);
        step();
        at_neg();
        check("hold_idle_grant", {31'd0, req1_ready}, 32'd1);
        check("hold_idle_a", {24'd0, alu_a}, 32'h44);
        step();
        req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        at_neg();
        check("hold_new_a", {24'd0, alu_a}, 32'h33);
        step(); step(); step();

        // Reset while in ISSUE.
        rsp0_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34; req0_op = 2'd0;
        at_neg();
        for (int i = 0; i < 10 && !req0_ready; i++) begin step(); at_neg(); end
        step();
        req0_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            check("midrst_valid0", {31'd0, rsp0_valid}, 32'd0);
            check("midrst_alu_a", {24'd0, alu_a}, 32'd0);
            check("midrst_rsp_y", {24'd0, rsp_y}, 32'd0);
            step();
        end
        req0_valid = 1'b1;
        at_neg();
        for (int i = 0; i < 10 && !req0_ready; i++) begin step(); at_neg(); end
        step();
        req0_valid = 1'b0;
        step();
        at_neg();
        check("after_rst_valid", {31'd0, rsp0_valid}, 32'd1);
        check("after_rst_y", {24'd0, rsp_y}, 32'h46);
        step(); step();

        // Spurious response-ready in IDLE must not move the pointer.
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        step(); step(); step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        at_neg();
        check("spur_first_grant", {31'd0, req1_ready}, FAIR ? 32'd1 : 32'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step(); step(); step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            step();
            rst = ($urandom_range(0, 199) == 0);
            if (!(req0_valid && !acc0 && !rst)) begin
                req0_valid = ($urandom_range(0, 99) < 60);
                req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 2'($urandom);
            end
            if (!(req1_valid && !acc1 && !rst)) begin
                req1_valid = ($urandom_range(0, 99) < 60);
                req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 2'($urandom);
            end
            rsp0_ready = $urandom_range(0, 1) == 1;
            rsp1_ready = $urandom_range(0, 1) == 1;
        end
        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and sequencer for the shared 8-bit combinational ALU (operands a/b, opcode op, result y, overflow flag). It accepts operations from two independent requesters over valid/ready, grants one at a time, registers the operands, drives them into the ALU, captures y/overflow and returns each result to the requester that issued it. It sits between the ALU's clients and the unmodified combinational ALU netlist, which has no clock of its own.

## Interface
- W, 8, operand/result width; must match the ALU datapath.
- OPW, 2, opcode width passed through to the ALU unchanged.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester n has an operation pending.
- req0_ready / req1_ready  out  1  operation from requester n accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  W  operands.
- req0_op / req1_op  in  OPW  opcode.
- alu_a, alu_b  out  W  registered operands to the ALU.
- alu_op  out  OPW  registered opcode to the ALU.
- alu_y  in  W  ALU result, combinational from alu_a/alu_b/alu_op.
- alu_ovf  in  1  ALU overflow flag.
- rsp0_valid / rsp1_valid  out  1  result for requester n is held.
- rsp0_ready / rsp1_ready  in  1  requester n takes the result.
- rsp_y  out  W  captured result, shared by both response ports.
- rsp_ovf  out  1  captured overflow, shared by both response ports.

## Operation
- FSM has three states: IDLE, ISSUE and RESP. Reset enters IDLE.
- IDLE:
  - If any reqN_valid is high, pick a winner (see Configuration) and assert reqN_ready for the winner only, combinationally, in the same cycle.
  - On the edge, latch the winner's a/b/op into alu_a/alu_b/alu_op, record the owner, and go to ISSUE.
  - The loser's ready stays 0, and its valid and payload must be held.
- ISSUE:
  - The ALU settles during this state.
  - On the edge, capture alu_y into rsp_y and alu_ovf into rsp_ovf, then go to RESP.
- RESP:
  - rspN_valid=1 for the owner only.
  - When rspN_ready=1, the handshake completes on that edge: go to IDLE, and update the round-robin pointer to prefer the other requester.
  - While ready=0, rsp_valid, rsp_y and rsp_ovf hold unchanged.
- Outside IDLE, both reqN_ready are 0. New requests wait and are not queued.
- alu_a/alu_b/alu_op keep their last latched value outside ISSUE, so the ALU inputs do not toggle.
- Width rules: no arithmetic is done in the block. y and ovf are passed through bit-exact, and op is passed through without decoding.
- Simultaneous events:
  - Both valid in IDLE: exactly one grant.
  - rspN_ready asserted while rspN_valid=0 is ignored.
  - reqN_valid deasserted in a cycle where its ready is low has no effect.
- Reset mid-operation:
  - Rst in any state forces IDLE on that edge and drops rsp*_valid.
  - An in-flight operation is discarded with no response.

## Timing
- Reset values:
  - state=IDLE and round-robin pointer=0 (prefers req0).
  - alu_a=0, alu_b=0, alu_op=0.
  - rsp_y=0, rsp_ovf=0.
  - rsp0_valid=0, rsp1_valid=0.
  - req*_ready=0 during the rst cycle.
- Latency: accept at edge T, capture at edge T+1, rspN_valid high from cycle T+1 (after edge T+1).
- Minimum occupancy is 3 cycles per operation (IDLE, ISSUE, RESP), so peak throughput is one operation per 3 cycles when the response is taken immediately.
- ALU path budget: one full clock from the alu_a/b/op registers to the rsp_y/rsp_ovf registers.

## Configuration
- ALU_ARB_FAIR_EN defined:
  - Round-robin arbitration. When both requesters are valid in IDLE, the one the pointer prefers wins.
  - The pointer flips to the other requester after each completed response handshake, regardless of which requester was served.
- Not defined:
  - Fixed priority: req0 always wins when valid, and req1 is granted only when req0_valid=0.
  - The pointer register is not built.

## Test plan
- Reset then single op: req0 a=8'h7F, b=8'h01, op=0 (add) valid at T.
  - req0_ready=1 at T.
  - rsp0_valid=1 from T+1 with rsp_y equal to the ALU output (8'h80) and rsp_ovf equal to the ALU flag (1).
- Contention, FAIR_EN: both valid continuously, rsp*_ready tied 1.
  - Grants alternate req0, req1, req0, … every 3 cycles.
  - Without the macro, all grants go to req0.
- Backpressure: rsp1_ready=0 for 5 cycles after rsp1_valid rises.
  - rsp1_valid, rsp_y and rsp_ovf stay stable.
  - req0_ready stays 0 throughout.
  - IDLE is re-entered one cycle after ready rises.
- Hold check: apply req1 a=8'h33, op=1 during ISSUE/RESP of a req0 op.
  - alu_a stays at the req0 value until req1 is granted in the next IDLE.
- Reset mid-op: assert rst in ISSUE.
  - rsp0_valid never rises, and all outputs return to the reset values listed above.
  - The next req0 op completes normally.
- Spurious ready: rsp0_ready=1 in IDLE.
  - No state change and no pointer update.
